// File: rtl/dcache_responder.sv
// Direct-mapped write-back / write-allocate data cache for the memory stage.
// Misses use a word-serial memory handshake; halt triggers a flush of dirty lines.
module dcache_responder #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic        halt_i,
    output logic [15:0] rdata_o,
    output logic        done_o,
    output logic        stall_o,
    output logic        hit_o,
    output logic        flushed_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_wr_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [15:0] mem_rdata_i
);
    localparam int SETS  = 1 << INDEX_BITS;
    localparam int TAG_W = 13 - INDEX_BITS;
    localparam int WA_W  = INDEX_BITS + 2;
    localparam logic [INDEX_BITS-1:0] LAST_SET = '1;
    localparam logic [INDEX_BITS-1:0] ONE_SET  = {{(INDEX_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WB     = 3'd1,
        S_FILL   = 3'd2,
        S_RETRY  = 3'd3,
        S_FLUSH  = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [INDEX_BITS-1:0]  set_q, set_d;
    logic                   flushed_q, flushed_d;
    logic                   op_wr_q;
    logic [15:1]            addr_q;
    logic [15:0]            wdata_q;
    logic [SETS-1:0]        valid_q, dirty_q;
    logic [TAG_W-1:0]       tag_q [SETS];
    logic [15:0]            data_q [4*SETS];

    logic [TAG_W-1:0]       req_tag_s, lat_tag_s;
    logic [INDEX_BITS-1:0]  req_idx_s, lat_idx_s, vd_idx_s;
    logic [1:0]             req_word_s, lat_word_s;
    logic                   req_s, illegal_s, lookup_hit_s, latch_s;
    logic                   we_s, tag_we_s, fill_done_s, dirty_set_s, dirty_clr_s, flush_adv_s;
    logic [WA_W-1:0]        we_addr_s;
    logic [15:0]            we_data_s;

    assign req_tag_s    = addr_i[15:3+INDEX_BITS];
    assign req_idx_s    = addr_i[2+INDEX_BITS:3];
    assign req_word_s   = addr_i[2:1];
    assign lat_tag_s    = addr_q[15:3+INDEX_BITS];
    assign lat_idx_s    = addr_q[2+INDEX_BITS:3];
    assign lat_word_s   = addr_q[2:1];
    assign req_s        = rd_i | wr_i;
    assign illegal_s    = (rd_i & wr_i) | (req_s & addr_i[0]);
    assign lookup_hit_s = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);

    // Next-state, array-write controls and CPU/memory-side outputs
    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;  set_d = set_q;  flushed_d = flushed_q;
        latch_s = 1'b0;  we_s = 1'b0;  we_addr_s = '0;  we_data_s = 16'h0000;
        tag_we_s = 1'b0;  fill_done_s = 1'b0;  dirty_set_s = 1'b0;  dirty_clr_s = 1'b0;
        vd_idx_s = '0;  flush_adv_s = 1'b0;
        rdata_o = 16'h0000;  done_o = 1'b0;  stall_o = 1'b0;  hit_o = 1'b0;  err_o = 1'b0;
        mem_req_o = 1'b0;  mem_wr_o = 1'b0;  mem_addr_o = 16'h0000;  mem_wdata_o = 16'h0000;
        flushed_o = flushed_q;
        case (state_q)
            S_IDLE: begin
                if (illegal_s) begin
                    err_o = 1'b1;
                end else if (req_s) begin
                    if (lookup_hit_s) begin
                        done_o = 1'b1;
                        hit_o  = 1'b1;
                        if (rd_i) begin
                            rdata_o = data_q[{req_idx_s, req_word_s}];
                        end else begin
                            we_s = 1'b1;  we_addr_s = {req_idx_s, req_word_s};  we_data_s = wdata_i;
                            dirty_set_s = 1'b1;  vd_idx_s = req_idx_s;
                        end
                    end else begin
                        stall_o = 1'b1;
                        latch_s = 1'b1;
                        cnt_d   = 2'd0;
                        state_d = (valid_q[req_idx_s] && dirty_q[req_idx_s]) ? S_WB : S_FILL;
                    end
                end else if (halt_i) begin
                    stall_o = 1'b1;  set_d = '0;  cnt_d = 2'd0;  state_d = S_FLUSH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                stall_o = 1'b1;  mem_req_o = 1'b1;  mem_wr_o = 1'b1;
                mem_addr_o  = {tag_q[lat_idx_s], lat_idx_s, cnt_q, 1'b0};
                mem_wdata_o = data_q[{lat_idx_s, cnt_q}];
                if (mem_ack_i) begin
                    if (cnt_q == 2'd3) begin
                        cnt_d = 2'd0;  state_d = S_FILL;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_FILL: begin
                stall_o = 1'b1;  mem_req_o = 1'b1;
                mem_addr_o = {lat_tag_s, lat_idx_s, cnt_q, 1'b0};
                if (mem_ack_i) begin
                    we_s = 1'b1;  we_addr_s = {lat_idx_s, cnt_q};  we_data_s = mem_rdata_i;
                    if (cnt_q == 2'd3) begin
                        cnt_d = 2'd0;  tag_we_s = 1'b1;  fill_done_s = 1'b1;
                        vd_idx_s = lat_idx_s;  state_d = S_RETRY;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_RETRY: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
                if (op_wr_q) begin
                    we_s = 1'b1;  we_addr_s = {lat_idx_s, lat_word_s};  we_data_s = wdata_q;
                    dirty_set_s = 1'b1;  vd_idx_s = lat_idx_s;
                end else begin
                    rdata_o = data_q[{lat_idx_s, lat_word_s}];
                end
            end
            S_FLUSH: begin
                stall_o = 1'b1;
                if (valid_q[set_q] && dirty_q[set_q]) begin
                    mem_req_o = 1'b1;  mem_wr_o = 1'b1;
                    mem_addr_o  = {tag_q[set_q], set_q, cnt_q, 1'b0};
                    mem_wdata_o = data_q[{set_q, cnt_q}];
                    if (mem_ack_i && (cnt_q == 2'd3)) begin
                        cnt_d = 2'd0;  dirty_clr_s = 1'b1;  vd_idx_s = set_q;  flush_adv_s = 1'b1;
                    end else if (mem_ack_i) begin
                        cnt_d = cnt_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    flush_adv_s = 1'b1;
                end
                if (flush_adv_s && (set_q == LAST_SET)) begin
                    set_d = '0;  flushed_d = 1'b1;  state_d = S_HALTED;
                end else if (flush_adv_s) begin
                    set_d = set_q + ONE_SET;
                end else begin
                    set_d = set_q;
                end
            end
            S_HALTED: begin
                if (req_s) begin
                    err_o = 1'b1;
                end else begin
                    err_o = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, latched request and line status bits
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;  cnt_q <= 2'd0;  set_q <= '0;  flushed_q <= 1'b0;
            op_wr_q <= 1'b0;  addr_q <= 15'h0000;  wdata_q <= 16'h0000;
            valid_q <= '0;  dirty_q <= '0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  set_q <= set_d;  flushed_q <= flushed_d;
            if (latch_s) begin
                op_wr_q <= wr_i;  addr_q <= addr_i[15:1];  wdata_q <= wdata_i;
            end
            if (fill_done_s) begin
                valid_q[vd_idx_s] <= 1'b1;  dirty_q[vd_idx_s] <= 1'b0;
            end else if (dirty_set_s) begin
                dirty_q[vd_idx_s] <= 1'b1;
            end else if (dirty_clr_s) begin
                dirty_q[vd_idx_s] <= 1'b0;
            end
        end
    end

    // Data and tag storage carry no reset; valid bits guard them
    always_ff @(posedge clk_i) begin
        if (we_s) begin
            data_q[we_addr_s] <= we_data_s;
        end
        if (tag_we_s) begin
            tag_q[lat_idx_s] <= lat_tag_s;
        end
    end
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Memory-side responder for the pipeline's memory stage: accepts one load/store per request, answers hits in the request cycle, and holds stall high on a miss.
- Direct-mapped, write-back, write-allocate data cache.
- Misses are serviced through a word-serial handshake to main memory.
- Includes a halt-time flush of all dirty lines before the processor stops.

Parameters:
- INDEX_BITS, 4: sets = 2^INDEX_BITS. Line = 4 words of 16 bits. Tag = addr[15:3+INDEX_BITS], index = addr[2+INDEX_BITS:3], word = addr[2:1].

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rd  in  1  CPU load request.
- wr  in  1  CPU store request.
- addr  in  16  CPU byte address; must be even.
- wdata  in  16  store data.
- halt  in  1  processor halting; request a flush.
- rdata  out  16  load data; valid when done=1 and the latched request was a load.
- done  out  1  request completes this cycle.
- stall  out  1  CPU must freeze the pipeline.
- hit  out  1  completion was a hit.
- flushed  out  1  flush finished; stays high until reset.
- err  out  1  illegal request this cycle.
- mem_req  out  1  main-memory word request.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  16  word-aligned memory address.
- mem_wdata  out  16  write-back data.
- mem_ack  in  1  memory accepts or returns the current word this cycle.
- mem_rdata  in  16  read data, valid with mem_ack.

Behaviour:
- Reset (rst=0, async): state=IDLE; all valid and dirty bits cleared; word and flush counters cleared; all outputs 0. The data and tag arrays are not reset.
- States: IDLE, WB, FILL, RETRY, FLUSH, HALTED.
- IDLE, illegal request: rd&wr, or (rd|wr)&addr[0] -> err=1 for that cycle; no state change, no array write, done=0.
- IDLE, legal request, hit (valid & tag match):
  - done=1, hit=1, stall=0 in the same cycle.
  - rdata = line word (combinational).
  - A store writes the word and sets dirty at the clock edge.
- IDLE, miss:
  - stall=1 in the detection cycle.
  - Latch rd, wr, addr, wdata.
  - Next state is WB if the victim is valid & dirty, else FILL.
  - While stall=1, CPU inputs are ignored.
- WB: mem_req=1, mem_wr=1, mem_addr={victim tag, index, cnt, 1'b0}, mem_wdata=line[cnt].
  - On mem_ack, cnt++. After the ack with cnt=3: cnt=0, go to FILL.
- FILL: mem_req=1, mem_wr=0, mem_addr={latched tag, index, cnt, 0}.
  - On mem_ack, line[cnt] <= mem_rdata, cnt++.
  - After the ack with cnt=3: write tag, valid=1, dirty=0, go to RETRY.
- mem_req stays high between words; a zero-wait memory acks every cycle.
- RETRY: done=1, hit=0, stall=0.
  - Load: rdata = filled word.
  - Store: write latched wdata and set dirty.
  - Next state IDLE.
- stall is 1 in the miss-detection cycle and in every WB/FILL cycle; it is 0 in RETRY, IDLE, and HALTED.
- Latency with a zero-wait memory:
  - Hit: 0 extra cycles.
  - Clean miss: stall for 5 cycles, done on cycle 6.
  - Dirty miss: stall for 9 cycles, done on cycle 10.
- halt in IDLE with no legal request pending -> FLUSH; stall=1. If halt coincides with a request, the request is served first.
- FLUSH: set counter s steps 0..2^INDEX_BITS-1.
  - A valid & dirty line is written back as 4 words (same handshake as WB), then its dirty bit is cleared.
  - A clean line takes one cycle.
  - After the last set: HALTED, flushed=1, stall=0. Requests in HALTED set err=1.
- mem_ack seen while mem_req=0 is ignored.
- Counters wrap only by explicit clearing; cnt never exceeds 3.
- Reset mid-miss or mid-flush aborts immediately; a partially written memory line is acceptable.

Test Plan:
- After reset: load 0x0010 with memory word n = 0x1000+n and a zero-wait memory.
  - Required: stall high 5 cycles; FILL mem_addr 0x0010, 0x0012, 0x0014, 0x0016; done=1, hit=0, rdata=0x1008 on cycle 6.
  - Immediately load 0x0014: done=1, hit=1, rdata=0x100A in the same cycle.
- Store 0xBEEF to 0x0012 (hit), then load 0x0092 (same index, different tag).
  - Required: WB writes 0x0010..0x0016, with 0xBEEF at 0x0012.
  - Then FILL from 0x0090..0x0096.
  - done on cycle 10, rdata=0x1049.
- Memory inserts 2 wait cycles per word on a clean miss.
  - Required: mem_req and mem_addr held stable through the waits; done on cycle 14.
- rd=wr=1, and separately rd=1 with addr=0x0011.
  - Required: err=1 for one cycle, no mem_req, no array change.
- Dirty lines in sets 1 and 5, then halt.
  - Required: exactly 8 write words; flushed=1 after the last set; a later rd gives err=1.
- Assert rst=0 during FILL word 2.
  - Required: mem_req=0 and stall=0 immediately; reloading the same address misses again.
